bus_rr_arbiter: RTL

//  Shares one 16-bit valid/ready sink (e.g. an s1-style receiver) between NREQ

---
 rtl/bus_rr_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready sink among NREQ requesters,
// with a per-grant burst limit and one cycle of arbitration in IDLE.
module bus_rr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 16,
    parameter int MAX_BURST = 4,
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int BW = $clog2(MAX_BURST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               m_valid,
    output logic [DW-1:0]      m_data,
    input  logic               m_ready,
    output logic [GW-1:0]      grant_id,
    output logic               busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state_r, state_nx_s;
    logic [GW-1:0] ptr_r, ptr_nx_s;
    logic [GW-1:0] grant_r, grant_nx_s;
    logic [BW-1:0] beat_cnt_r, beat_cnt_nx_s;
    logic [GW-1:0] pick_s;
    logic [GW-1:0] idx_s;
    logic [GW-1:0] next_ptr_s;
    logic          found_s;
    logic          any_req_s;
    logic          owner_valid_s;
    logic          beat_s;
    logic          last_beat_s;

    assign any_req_s     = |req_valid;
    assign owner_valid_s = req_valid[grant_r];
    assign beat_s        = m_valid & m_ready;
    assign last_beat_s   = (beat_cnt_r == BW'(MAX_BURST - 1));
    assign next_ptr_s    = (grant_r == GW'(NREQ - 1)) ? {GW{1'b0}} : grant_r + GW'(1);
    assign grant_id      = grant_r;
    assign busy          = (state_r == OWN);

    // First valid requester in scan order ptr, ptr+1, ... wrapping at NREQ
    always_comb begin
        pick_s  = ptr_r;
        found_s = 1'b0;
        idx_s   = {GW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            idx_s = GW'((int'(ptr_r) + k) % NREQ);
            if (!found_s && req_valid[idx_s]) begin
                pick_s  = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state: grant on any request, release on burst limit or owner withdrawal
    always_comb begin
        state_nx_s    = state_r;
        ptr_nx_s      = ptr_r;
        grant_nx_s    = grant_r;
        beat_cnt_nx_s = beat_cnt_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_nx_s = OWN;
                    grant_nx_s = pick_s;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            OWN: begin
                if (!owner_valid_s || (beat_s && last_beat_s)) begin
                    state_nx_s    = IDLE;
                    ptr_nx_s      = next_ptr_s;
                    beat_cnt_nx_s = {BW{1'b0}};
                end else if (beat_s) begin
                    beat_cnt_nx_s = beat_cnt_r + BW'(1);
                end else begin
                    beat_cnt_nx_s = beat_cnt_r;
                end
            end
            default: begin
                state_nx_s    = IDLE;
                beat_cnt_nx_s = {BW{1'b0}};
            end
        endcase
    end

    // Downstream mux and ready return; all idle outputs are zero so reset clears them at once
    always_comb begin
        m_valid   = 1'b0;
        m_data    = {DW{1'b0}};
        req_ready = {NREQ{1'b0}};
        if (state_r == OWN) begin
            m_valid            = owner_valid_s;
            m_data             = req_data[int'(grant_r)*DW +: DW];
            req_ready[grant_r] = m_ready;
        end else begin
            m_valid = 1'b0;
        end
    end

    // Arbiter state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= {GW{1'b0}};
            grant_r    <= {GW{1'b0}};
            beat_cnt_r <= {BW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            ptr_r      <= ptr_nx_s;
            grant_r    <= grant_nx_s;
            beat_cnt_r <= beat_cnt_nx_s;
        end
    end

endmodule
